// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the pooling window datapath.
//   pool_mode_e : pooling operator selected per window (max or average)
//   clog2       : ceiling log2, usable in constant expressions
//   acc_width   : accumulator width that holds a full POOL_SIZE x POOL_SIZE
//                 signed sum without overflow
package cnn_pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) result = result + 1;
      end
      return result;
   endfunction

   function automatic int acc_width(input int bit_width, input int pool_size);
      return bit_width + clog2(pool_size * pool_size);
   endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel lane of the pooling window unit: column reduce, window
// accumulator and final-value formation.
//
// Optional build macro: POOL_FUSED_RELU_EN clamps negative final values to 0.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   accept     in   a beat is consumed this cycle
//   win_start  in   the beat (if any) is the first column of a window
//   avg        in   effective mode for this beat: 1 = average, 0 = max
//   col        in   POOL_SIZE signed samples, row r at r*BIT_WIDTH
//   lane_out   out  final pooled value if this beat closes the window
module pool_lane
   import cnn_pool_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int POOL_SIZE = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           accept,
   input  logic                           win_start,
   input  logic                           avg,
   input  logic [POOL_SIZE*BIT_WIDTH-1:0] col,
   output logic [BIT_WIDTH-1:0]           lane_out
);

   localparam int SHIFT = clog2(POOL_SIZE * POOL_SIZE);
   localparam int ACC_W = acc_width(BIT_WIDTH, POOL_SIZE);

   logic signed [ACC_W-1:0] sample_ext [POOL_SIZE];
   logic signed [ACC_W-1:0] col_max;
   logic signed [ACC_W-1:0] col_sum;
   logic signed [ACC_W-1:0] reduce;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic [BIT_WIDTH-1:0]    final_val;

   always_comb begin
      for (int r = 0; r < POOL_SIZE; r++) begin
         sample_ext[r] = {{(ACC_W-BIT_WIDTH){col[r*BIT_WIDTH+BIT_WIDTH-1]}},
                          col[r*BIT_WIDTH +: BIT_WIDTH]};
      end

      col_max = sample_ext[0];
      col_sum = sample_ext[0];
      for (int r = 1; r < POOL_SIZE; r++) begin
         if (sample_ext[r] > col_max) col_max = sample_ext[r];
         col_sum = col_sum + sample_ext[r];
      end

      reduce = avg ? col_sum : col_max;

      if (win_start)       acc_next = reduce;
      else if (avg)        acc_next = acc + reduce;
      else if (reduce > acc) acc_next = reduce;
      else                 acc_next = acc;

      // ACC_W = BIT_WIDTH + SHIFT, so taking the top BIT_WIDTH bits is the
      // arithmetic right shift by SHIFT (floor division by POOL_SIZE^2).
      // A max result always fits in the low BIT_WIDTH bits.
      final_val = avg ? acc_next[SHIFT +: BIT_WIDTH] : acc_next[BIT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (accept) begin
         acc <= acc_next;
      end
   end

`ifdef POOL_FUSED_RELU_EN
   assign lane_out = final_val[BIT_WIDTH-1] ? '0 : final_val;
`else
   assign lane_out = final_val;
`endif

endmodule

// File: rtl/pool_window_unit.sv
// Non-overlapping POOL_SIZE x POOL_SIZE pooling (stride POOL_SIZE) over
// NUM_CH lanes, max or average per window, valid/ready on both sides.
// Each input beat is one POOL_SIZE-row column per lane; a window closes on
// its last column or early on in_last (partial window, zero padded).
//
// Optional build macro: POOL_FUSED_RELU_EN (ReLU clamp on every lane result).
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   mode         in   0 = max, 1 = average; sampled on a window's first beat
//   in_valid     in   input beat valid
//   in_ready     out  input beat accepted when in_valid && in_ready
//   in_data      in   lane c row r at (c*POOL_SIZE+r)*BIT_WIDTH, signed
//   in_last      in   last column of the row band; closes a partial window
//   out_valid    out  pooled result valid
//   out_ready    in   downstream accepts the result
//   out_data     out  lane c at c*BIT_WIDTH, signed
//   out_partial  out  result came from a window closed early by in_last
module pool_window_unit
   import cnn_pool_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int POOL_SIZE = 2,
   parameter int NUM_CH    = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  mode,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NUM_CH*POOL_SIZE*BIT_WIDTH-1:0] in_data,
   input  logic                                  in_last,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NUM_CH*BIT_WIDTH-1:0]           out_data,
   output logic                                  out_partial
);

   localparam int               CNT_W    = (clog2(POOL_SIZE) < 1) ? 1 : clog2(POOL_SIZE);
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(POOL_SIZE - 1);

   logic [CNT_W-1:0]          col_cnt;
   pool_mode_e                win_mode;
   pool_mode_e                eff_mode;
   logic                      accept;
   logic                      win_start;
   logic                      at_last_col;
   logic                      close;
   logic [NUM_CH*BIT_WIDTH-1:0] lane_result;

   // Stall input only while a result is waiting on downstream; this also
   // guarantees a close can never coincide with a stalled output.
   assign in_ready    = !(out_valid && !out_ready);
   assign accept      = in_valid && in_ready;
   assign win_start   = (col_cnt == '0);
   assign at_last_col = (col_cnt == LAST_COL);
   assign close       = accept && (at_last_col || in_last);

   // The first beat of a window uses the live mode; later beats use the
   // mode latched at window start so mid-window changes are ignored.
   assign eff_mode = win_start ? pool_mode_e'(mode) : win_mode;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      pool_lane #(
         .BIT_WIDTH (BIT_WIDTH),
         .POOL_SIZE (POOL_SIZE)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .accept    (accept),
         .win_start (win_start),
         .avg       (eff_mode == POOL_AVG),
         .col       (in_data[c*POOL_SIZE*BIT_WIDTH +: POOL_SIZE*BIT_WIDTH]),
         .lane_out  (lane_result[c*BIT_WIDTH +: BIT_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt     <= '0;
         win_mode    <= POOL_MAX;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_partial <= 1'b0;
      end else begin
         if (accept) begin
            if (win_start) win_mode <= eff_mode;
            col_cnt <= close ? '0 : col_cnt + CNT_W'(1);
         end

         // A close in the same cycle as a pop keeps out_valid high with the
         // new window, giving one result per POOL_SIZE beats sustained.
         if (close) begin
            out_valid   <= 1'b1;
            out_data    <= lane_result;
            out_partial <= !at_last_col;
         end else if (out_ready) begin
            out_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pool_window_unit.sv
module tb_pool_window_unit;

   localparam int BW = 16;
   localparam int PS = 2;
   localparam int NC = 2;

   logic              clk;
   logic              rst_n;
   logic              mode;
   logic              in_valid;
   logic              in_ready;
   logic [NC*PS*BW-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [NC*BW-1:0]  out_data;
   logic              out_partial;

   int checks   = 0;
   int failures = 0;

   pool_window_unit #(
      .BIT_WIDTH (BW),
      .POOL_SIZE (PS),
      .NUM_CH    (NC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_partial (out_partial)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [NC*PS*BW-1:0] pk(input int a0, input int a1,
                                              input int b0, input int b1);
      return {16'(b1), 16'(b0), 16'(a1), 16'(a0)};
   endfunction

   function automatic logic [NC*BW-1:0] ex(input int l0, input int l1);
      return {16'(l1), 16'(l0)};
   endfunction

   // Starts and ends at a negedge; the beat is presented for one posedge.
   task automatic beat(input logic m, input int a0, input int a1,
                       input int b0, input int b1, input logic last);
      mode     = m;
      in_data  = pk(a0, a1, b0, b1);
      in_last  = last;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      checks++;
      if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", out_data); end
      checks++;
      if (out_partial !== 1'b0) begin failures++; $display("FAIL reset_partial got=%b want=0", out_partial); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_max();
      beat(0, 3, -7, -4, -2, 0);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL max_midwin_valid got=%b want=0", out_valid); end
      beat(0, 9, 1, -8, -5, 0);
      idle();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL max_valid got=%b want=1", out_valid); end
      checks++;
      if (out_data !== ex(9, -2)) begin failures++; $display("FAIL max_data got=%h want=%h", out_data, ex(9, -2)); end
      checks++;
      if (out_partial !== 1'b0) begin failures++; $display("FAIL max_partial got=%b want=0", out_partial); end
      // in_last on the natural last column is a full window, not partial
      beat(0, -100, -200, 5, 5, 0);
      beat(0, -300, -150, 4, 6, 1);
      idle();
      checks++;
      if (out_data !== ex(-100, 6)) begin failures++; $display("FAIL max_last_data got=%h want=%h", out_data, ex(-100, 6)); end
      checks++;
      if (out_partial !== 1'b0) begin failures++; $display("FAIL max_last_partial got=%b want=0", out_partial); end
   endtask

   task automatic test_avg();
      beat(1, 1, 2, -1, -1, 0);
      beat(1, 3, 5, -1, -2, 0);
      idle();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL avg_valid got=%b want=1", out_valid); end
      checks++;
      if (out_data !== ex(2, -2)) begin failures++; $display("FAIL avg_data got=%h want=%h", out_data, ex(2, -2)); end
   endtask

   task automatic test_partial();
      beat(1, 8, 8, -3, -4, 1);
      idle();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL partial_valid got=%b want=1", out_valid); end
      checks++;
      if (out_data !== ex(4, -2)) begin failures++; $display("FAIL partial_data got=%h want=%h", out_data, ex(4, -2)); end
      checks++;
      if (out_partial !== 1'b1) begin failures++; $display("FAIL partial_flag got=%b want=1", out_partial); end
      // column counter must be back at 0: a single beat must not close
      beat(0, 1, 2, 0, -9, 0);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL partial_cnt_reset got=%b want=0", out_valid); end
      beat(0, 5, 0, -1, -7, 0);
      idle();
      checks++;
      if (out_data !== ex(5, 0)) begin failures++; $display("FAIL partial_next_data got=%h want=%h", out_data, ex(5, 0)); end
      checks++;
      if (out_partial !== 1'b0) begin failures++; $display("FAIL partial_next_flag got=%b want=0", out_partial); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      beat(1, 4, 4, -8, 0, 1);
      checks++;
      if (out_data !== ex(2, -2) || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_0 got=%h/%b want=%h/1", out_data, out_valid, ex(2, -2)); end
      beat(1, -1, 0, 12, 0, 1);
      checks++;
      if (out_data !== ex(-1, 3) || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_1 got=%h/%b want=%h/1", out_data, out_valid, ex(-1, 3)); end
      beat(1, 7, 6, 3, 0, 1);
      checks++;
      if (out_data !== ex(3, 0) || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_2 got=%h/%b want=%h/1", out_data, out_valid, ex(3, 0)); end
      idle();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      beat(0, 1, 2, -1, -2, 0);
      beat(0, 3, 4, -3, -4, 0);
      // next window's first beat is offered throughout the stall
      mode     = 1'b0;
      in_data  = pk(10, 0, 7, 7);
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
         checks++;
         if (out_valid !== 1'b1 || out_data !== ex(4, -1)) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h/%b want=%h/1", i, out_data, out_valid, ex(4, -1)); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b want=0", out_valid); end
      beat(0, -5, 6, 8, -9, 0);
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ex(10, 8)) begin failures++; $display("FAIL bp_second got=%h/%b want=%h/1", out_data, out_valid, ex(10, 8)); end
   endtask

   task automatic test_mode_switch();
      beat(1, 4, 4, -6, 2, 0);
      beat(0, 8, 0, 1, 1, 0);
      idle();
      checks++;
      if (out_data !== ex(4, -1)) begin failures++; $display("FAIL mode_avg got=%h want=%h", out_data, ex(4, -1)); end
      beat(0, 4, 4, -6, 2, 0);
      beat(1, 8, 0, 1, 1, 0);
      idle();
      checks++;
      if (out_data !== ex(8, 2)) begin failures++; $display("FAIL mode_max got=%h want=%h", out_data, ex(8, 2)); end
   endtask

   task automatic test_reset_mid();
      beat(1, 8, 8, 4, 4, 1);
      idle();
      checks++;
      if (out_data !== ex(4, 2) || out_partial !== 1'b1) begin failures++; $display("FAIL rm_pre got=%h/%b want=%h/1", out_data, out_partial, ex(4, 2)); end
      beat(1, 100, 100, -50, -50, 0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b want=0", out_valid); end
      checks++;
      if (out_data !== '0) begin failures++; $display("FAIL rm_data got=%h want=0", out_data); end
      checks++;
      if (out_partial !== 1'b0) begin failures++; $display("FAIL rm_partial got=%b want=0", out_partial); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      beat(1, 1, 1, 2, 2, 0);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_residue got=%b want=0", out_valid); end
      beat(1, 1, 1, 2, 2, 0);
      idle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ex(1, 2) || out_partial !== 1'b0) begin
         failures++;
         $display("FAIL rm_after got=%h/%b/%b want=%h/1/0", out_data, out_valid, out_partial, ex(1, 2));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_max();
      test_avg();
      test_partial();
      test_back_to_back();
      test_backpressure();
      test_mode_switch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pool_window_unit.md
Name: pool_window_unit

Overview:
- Parametrised successor of the two-row pooling shift buffer.
- Performs non-overlapping POOL_SIZE x POOL_SIZE pooling (stride = POOL_SIZE) on NUM_CH independent channel lanes.
- Selectable max or average mode, with valid/ready handshakes on both sides.
- Sits between the convolution/activation stage, which supplies one POOL_SIZE-row column per channel per beat, and the next layer's line buffer.

Parameters:
- BIT_WIDTH, 32: signed sample width, input and output.
- POOL_SIZE, 2: window edge in rows and columns. Must be a power of 2, range 2..8.
- NUM_CH, 2: number of parallel channel lanes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = max pooling, 1 = average pooling. Sampled on the first beat of each window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  NUM_CH*POOL_SIZE*BIT_WIDTH  signed samples. Lane c, row r is at index (c*POOL_SIZE+r)*BIT_WIDTH.
- in_last  in  1  last column of the current row band; closes a partial window.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_CH*BIT_WIDTH  signed pooled value per lane, lane c at c*BIT_WIDTH.
- out_partial  out  1  result came from a window closed early by in_last.

Behaviour:
- Reset (async assert, sync-safe release):
  - col_cnt=0; accumulators=0; win_mode=0.
  - out_valid=0, out_data=0, out_partial=0.
  - in_ready=1 once out of reset.
- Handshake:
  - in_ready = !(out_valid && !out_ready), purely combinational.
  - A beat is accepted iff in_valid && in_ready.
  - out_data and out_partial hold stable while out_valid && !out_ready.
- Column reduce (combinational, per lane):
  - max mode: max of the POOL_SIZE row samples.
  - avg mode: signed sum, width ACC_W = BIT_WIDTH + log2(POOL_SIZE*POOL_SIZE).
- Accumulate:
  - On an accepted beat with col_cnt==0: acc <= column reduce, and win_mode <= mode.
  - Otherwise: acc <= max(acc, reduce) in max mode, or acc + reduce in avg mode.
  - mode changes mid-window are ignored until the next window starts.
- Window close: an accepted beat where col_cnt==POOL_SIZE-1 or in_last==1.
  - col_cnt returns to 0 on close; otherwise col_cnt increments.
  - On the next edge: out_valid<=1, out_data<=final value, out_partial <= (in_last && col_cnt!=POOL_SIZE-1).
  - Latency: one cycle from the closing beat to out_valid.
- Final value:
  - max mode: acc, with the closing column included.
  - avg mode: (acc + reduce) >>> log2(POOL_SIZE*POOL_SIZE), arithmetic shift, truncates toward minus infinity.
  - Partial windows still divide by the full POOL_SIZE^2 (zero-padding semantics).
- out_valid clears on out_valid && out_ready unless a new close occurs in the same cycle, in which case it stays 1 with the new data. Back-to-back windows sustain full throughput.
- Simultaneous close and stall cannot occur, because in_ready=0 while stalled.
- No overflow in avg mode, since the accumulator is sized to ACC_W. Max mode compares signed values.
- Reset mid-window discards the partial window. No output is produced for it.

Optional Feature:
- Macro POOL_FUSED_RELU_EN.
- Defined: each lane's final value is clamped, negative to 0, before it is registered into out_data. Latency is unchanged.
- Undefined: signed results pass unmodified. No clamp logic is generated.

Decomposition:
- Shared package cnn_pool_pkg:
  - pool_mode_e enum (POOL_MAX=0, POOL_AVG=1).
  - clog2 function.
  - ACC_W derivation function.
- Sub-module pool_lane, generated NUM_CH times. It holds one lane's column reduce, accumulator and final-value logic.
- The top level owns col_cnt, win_mode, the handshake and the output register.

Test Plan (BIT_WIDTH=16, POOL_SIZE=2, NUM_CH=2):
1. Max: lane0 beats {3,-7} then {9,1}, lane1 {-4,-2} then {-8,-5}, out_ready=1 -> one cycle later out_valid=1, lane0=9, lane1=-2, out_partial=0.
2. Avg: lane0 {1,2},{3,5} -> 11>>>2 = 2. Lane1 {-1,-1},{-1,-2} -> -5>>>2 = -2.
3. Partial: avg mode, single beat {8,8} with in_last=1 -> out 16>>>2 = 4, out_partial=1, col_cnt back to 0.
4. Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable for 5 cycles. Raise out_ready with a new window pending -> both windows emitted in order with no loss.
5. Mode switch: mode=1 on beat 1 of a window, mode=0 on beat 2 -> averaged result. The next window uses max.
6. Reset: assert rst_n=0 mid-window -> all outputs 0 immediately. After release, a full window produces a correct result with no residue.
